// File: rtl/decoder_pkg.sv
// Shared definitions for the request encoder and its matching 2-to-4 decoder.
//   state_t    : grant FSM states (IDLE, GRANT)
//   NUM_LINES  : number of request lines
//   ADDR_W     : width of the encoded index
//   RST_LAST   : round-robin pointer after reset, chosen so index 0 is searched first
//   onehot()   : expands an index into a one-hot line vector
package decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_LINES = 4;
    localparam int ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] RST_LAST = 2'b11;

    function automatic logic [NUM_LINES-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NUM_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational priority search over a request vector.
//   vec   : candidate bits
//   start : first index searched when mode=1 (rotating); ignored when mode=0
//   mode  : 1 = search start, start+1, ... (mod NUM_LINES); 0 = search 0,1,2,3
//   index : first set bit found in search order (0 when none found)
//   found : at least one bit of vec is set
module priority_pick
    import decoder_pkg::*;
(
    input  logic [NUM_LINES-1:0] vec,
    input  logic [ADDR_W-1:0]    start,
    input  logic                 mode,
    output logic [ADDR_W-1:0]    index,
    output logic                 found
);

    logic [ADDR_W-1:0]    base;
    logic [ADDR_W-1:0]    pos [NUM_LINES];
    logic [NUM_LINES-1:0] hit;

    assign base = mode ? start : '0;

    // pos[k] is the k-th index in search order; addition wraps modulo 4.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_order
            assign pos[gi] = base + ADDR_W'(gi);
            assign hit[gi] = vec[pos[gi]];
        end
    endgenerate

    // Scan from the back so the earliest hit in search order wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int k = NUM_LINES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                index = pos[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Sequential 4-to-2 request encoder with sticky pending bits and valid/ack handshake.
//   clk                : rising-edge clock
//   reset              : asynchronous active-high reset
//   in0..in3           : request lines, sampled each edge while enable=1
//   enable             : allow capture of new requests
//   ack                : consumer accepts the presented index (only while valid=1)
//   address0/address1  : registered index of the granted line (address1 = MSB)
//   valid              : registered, address holds a pending index
//   pending            : registered sticky request bits
// ROUND_ROBIN=1 rotates priority starting after the last accepted index;
// ROUND_ROBIN=0 gives fixed priority with in0 highest.
module request_encoder
    import decoder_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in0,
    input  logic                 in1,
    input  logic                 in2,
    input  logic                 in3,
    input  logic                 enable,
    input  logic                 ack,
    output logic                 address0,
    output logic                 address1,
    output logic                 valid,
    output logic [NUM_LINES-1:0] pending
);

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic [ADDR_W-1:0]    last_reg, last_next;
    logic [NUM_LINES-1:0] pending_reg, pending_next;

    logic                 accept;
    logic [NUM_LINES-1:0] clr;
    logic [NUM_LINES-1:0] set;
    logic [ADDR_W-1:0]    search_start;
    logic [ADDR_W-1:0]    pick_index;
    logic                 pick_found;

    // Pending update and pointer advance. The pick must see the pointer as it
    // will be after this edge so back-to-back grants rotate correctly.
    always_comb begin
        accept       = (state_reg == GRANT) && ack;
        clr          = accept ? onehot(addr_reg) : '0;
        set          = enable ? {in3, in2, in1, in0} : '0;
        pending_next = (pending_reg & ~clr) | set;   // set wins over clear
        last_next    = accept ? addr_reg : last_reg;
        search_start = last_next + ADDR_W'(1);
    end

    priority_pick u_pick (
        .vec   (pending_next),
        .start (search_start),
        .mode  (ROUND_ROBIN),
        .index (pick_index),
        .found (pick_found)
    );

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    addr_next  = pick_index;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // Without ack the presented index is frozen even if new bits arrive.
                if (ack) begin
                    if (pick_found) begin
                        addr_next = pick_index;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            last_reg    <= RST_LAST;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            last_reg    <= last_next;
            pending_reg <= pending_next;
        end
    end

    assign address0 = addr_reg[0];
    assign address1 = addr_reg[1];
    assign valid    = (state_reg == GRANT);
    assign pending  = pending_reg;

endmodule

// File: tb/tb_request_encoder.sv
// Directed testbench for request_encoder: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_request_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
    logic enable = 1'b0;
    logic ack = 1'b0;

    logic       a0_rr, a1_rr, v_rr;
    logic [3:0] p_rr;
    logic       a0_fx, a1_fx, v_fx;
    logic [3:0] p_fx;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    request_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .enable(enable), .ack(ack), .address0(a0_rr), .address1(a1_rr),
        .valid(v_rr), .pending(p_rr)
    );

    request_encoder #(.ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .enable(enable), .ack(ack), .address0(a0_fx), .address1(a1_fx),
        .valid(v_fx), .pending(p_fx)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the round-robin instance: valid, address, pending.
    task automatic chk_rr(input string tag, input logic v, input logic [1:0] a, input logic [3:0] p);
        check({tag, " rr valid"}, {7'd0, v_rr}, {7'd0, v});
        if (v) check({tag, " rr addr"}, {6'd0, a1_rr, a0_rr}, {6'd0, a});
        check({tag, " rr pending"}, {4'd0, p_rr}, {4'd0, p});
        $display("step %-16s rr: valid=%0b addr=%0d pending=%b", tag, v_rr, {a1_rr, a0_rr}, p_rr);
    endtask

    task automatic chk_fx(input string tag, input logic v, input logic [1:0] a);
        check({tag, " fx valid"}, {7'd0, v_fx}, {7'd0, v});
        if (v) check({tag, " fx addr"}, {6'd0, a1_fx, a0_fx}, {6'd0, a});
        $display("step %-16s fx: valid=%0b addr=%0d", tag, v_fx, {a1_fx, a0_fx});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int s1, sother;
        logic [1:0] seq_rr [6];
        logic [1:0] seq_rr_tail [3];
        logic [1:0] seq_fx_tail [3];
        seq_rr      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq_rr_tail = '{2'd2, 2'd3, 2'd0};
        seq_fx_tail = '{2'd1, 2'd2, 2'd3};

        // Reset state
        #12;
        chk_rr("reset", 1'b0, 2'd0, 4'b0000);
        check("reset addr", {6'd0, a1_rr, a0_rr}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request on in2, held without ack
        step();
        enable = 1'b1; in2 = 1'b1;
        step();
        chk_rr("single", 1'b1, 2'd2, 4'b0100);
        in2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_rr("hold", 1'b1, 2'd2, 4'b0100);
        end
        ack = 1'b1;
        step();
        chk_rr("single ack", 1'b0, 2'd0, 4'b0000);
        ack = 1'b0;

        // Reset mid-grant with pending=1010 (last=2 so index 3 is granted)
        in1 = 1'b1; in3 = 1'b1;
        step();
        chk_rr("pre-reset", 1'b1, 2'd3, 4'b1010);
        in1 = 1'b0; in3 = 1'b0; enable = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_rr("async reset", 1'b0, 2'd0, 4'b0000);
        check("async reset addr", {6'd0, a1_rr, a0_rr}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        chk_rr("post-reset idle", 1'b0, 2'd0, 4'b0000);

        // Enable gating
        in3 = 1'b1;
        step();
        chk_rr("gated", 1'b0, 2'd0, 4'b0000);
        step();
        chk_rr("gated2", 1'b0, 2'd0, 4'b0000);
        enable = 1'b1;
        step();
        chk_rr("enable edge", 1'b1, 2'd3, 4'b1000);
        enable = 1'b0; in3 = 1'b0; ack = 1'b1;
        step();
        chk_rr("gate ack", 1'b0, 2'd0, 4'b0000);
        ack = 1'b0;

        // Fairness: all lines held, ack held
        pulse_reset();
        enable = 1'b1; ack = 1'b1;
        in0 = 1'b1; in1 = 1'b1; in2 = 1'b1; in3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_rr("rr seq", 1'b1, seq_rr[i], 4'b1111);
            chk_fx("fx seq", 1'b1, 2'd0);
        end
        // Drain with enable low: pending empties one grant per cycle
        enable = 1'b0;
        in0 = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rr drain addr", {6'd0, a1_rr, a0_rr}, {6'd0, seq_rr_tail[i]});
            check("rr drain valid", {7'd0, v_rr}, 8'd1);
            chk_fx("fx drain", 1'b1, seq_fx_tail[i]);
        end
        step();
        chk_rr("rr drained", 1'b0, 2'd0, 4'b0000);
        chk_fx("fx drained", 1'b0, 2'd0);
        ack = 1'b0;

        // Set-over-clear on index 1
        pulse_reset();
        enable = 1'b1; in1 = 1'b1; in3 = 1'b1;
        step();
        chk_rr("soc grant1", 1'b1, 2'd1, 4'b1010);
        ack = 1'b1;
        step();
        chk_rr("soc re-set", 1'b1, 2'd3, 4'b1010);
        in1 = 1'b0; in3 = 1'b0;
        step();
        chk_rr("soc again1", 1'b1, 2'd1, 4'b0010);
        step();
        chk_rr("soc done", 1'b0, 2'd0, 4'b0000);

        // Decoder loopback: count out1 strobes of a 2-to-4 decoder on the outputs
        s1 = 0; sother = 0;
        in1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            in1 = 1'b0;
            if (v_rr && {a1_rr, a0_rr} == 2'd1) s1++;
            else if (v_rr) sother++;
        end
        check("loopback out1 strobes", 8'(s1), 8'd1);
        check("loopback other strobes", 8'(sother), 8'd0);
        $display("step loopback       out1 strobes=%0d other=%0d", s1, sother);
        ack = 1'b0; enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
# request_encoder

Sequential 4-to-2 request encoder, the inverse of the team's 2-to-4 decoder. Latches four single-bit request lines as sticky pending bits and presents one pending index at a time as a 2-bit address with a valid/ack handshake. address0/address1/valid connect directly to the decoder's address0/address1/enable inputs, so an accepted grant re-expands to a one-hot strobe. Priority is rotating round-robin by default, with fixed priority selectable.

## Interface
- ROUND_ROBIN, default 1: 1 = rotating priority starting after the last accepted index; 0 = fixed priority, in0 highest, in3 lowest.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in0, in1, in2, in3  input  1 each  request lines, level-sampled on each rising clk edge.
- enable  input  1  1 = capture requests this edge; 0 = no new captures. Existing pending bits are still presented.
- ack  input  1  consumer accepts the current address; meaningful only while valid=1.
- address0, address1  output  1 each  registered encoded index (address1 is the MSB).
- valid  output  1  registered; address0/address1 hold a pending index.
- pending  output  4  registered sticky request bits; bit i corresponds to in_i.

## Operation
- Internal state:
  - pending[3:0].
  - State register: IDLE or GRANT. valid = (state == GRANT).
  - Address register: 2 bits.
  - Round-robin pointer last[1:0]: index of the last accepted grant.
- Per-edge update:
  - accept = valid & ack.
  - clr = one-hot(address) if accept, else 0.
  - set = {in3,in2,in1,in0} if enable, else 0.
  - pending_n = (pending & ~clr) | set.
  - Set wins over clear on the same bit: a re-asserted request stays pending.
- Selection from pending_n (combinational):
  - ROUND_ROBIN=1: search order last+1, last+2, last+3, last (mod 4).
  - ROUND_ROBIN=0: search order 0, 1, 2, 3.
- IDLE:
  - pending_n == 0: stay IDLE; address holds its value.
  - Otherwise: load the selected index into address and go to GRANT.
- GRANT:
  - ack=0: address and valid hold stable. pending may gain bits, but the presented index never changes.
  - ack=1: last <= address. If pending_n != 0, load the next selection (computed with the updated pointer) and stay in GRANT, giving back-to-back grants with no bubble. Otherwise go to IDLE.
- ack while valid=0 is ignored and has no effect on any state.
- enable=0 while valid=1: the handshake continues normally and pending drains.

## Timing
- Reset values: address0=0, address1=0, valid=0, pending=4'b0000, last=2'b11 (index 0 is searched first after reset), state=IDLE.
- Reset asserted mid-grant clears all outputs asynchronously without waiting for clk. The first capture happens on the first rising edge after reset deasserts.
- Latency: in_i=1 with enable=1 before edge N, IDLE → valid=1 with address=i after edge N (1 cycle).
- Throughput: 1 grant per cycle while ack is held high and pending_n is nonzero.
- Address is valid only while valid=1. Consumers must not use it while valid=0.
- All outputs are driven from registers; no combinational path from any input to any output.

## Structure
- Shared package decoder_pkg:
  - state enum {IDLE, GRANT}.
  - NUM_LINES=4.
  - ADDR_W=2.
  - RST_LAST=2'b11.
- One sub-module, priority_pick, purely combinational:
  - Inputs: 4-bit vector, 2-bit start, mode.
  - Outputs: 2-bit index and found flag.
  - Instantiated once on pending_n.
- Top level holds only the registers and the FSM; target 150–250 lines in total.

## Test plan
- Reset: assert reset mid-grant with pending=4'b1010, valid=1 → outputs drop to 0, pending=0, valid=0 before the next edge. After release with no requests, valid stays 0.
- Single request: enable=1, in2 pulsed for one cycle → valid=1, address=2'b10 one edge later. Hold ack=0 for 5 cycles → address stable, pending=4'b0100. Assert ack for one cycle → valid=0, pending=0.
- Round-robin fairness: in0..in3 all held high, enable=1, ack=1 continuously → grant sequence 0,1,2,3,0,1,… with valid never dropping. With ROUND_ROBIN=0, the same stimulus yields 0,0,0,….
- Set-over-clear: while address=1 is granted, assert ack and in1 together → pending[1] stays 1 and index 1 is presented again once its turn comes.
- Enable gating: enable=0 while in3=1 → pending stays 0 and valid=0. Raise enable for one edge → address=2'b11, valid=1.
- Decoder loopback: connect the outputs to the 2-to-4 decoder, ack=1 and in1 pulsed → exactly one out1 strobe results.
